// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin register-file write-port arbiter with locked bursts; optional stats via REGARB_STATS_EN
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
) (
    input  logic                      i_CLK,
    input  logic                      i_RST,
    input  logic                      i_Stall,
    input  logic [NUM_REQ-1:0]        i_Req,
    input  logic [NUM_REQ-1:0]        i_Lock,
    input  logic [NUM_REQ*ADDR_W-1:0] i_Addr,
    input  logic [NUM_REQ*DATA_W-1:0] i_Data,
    output logic [NUM_REQ-1:0]        o_Grant,
    output logic                      o_RegWrite,
    output logic [ADDR_W-1:0]         o_Write_Reg_Addr,
    output logic [DATA_W-1:0]         o_Write_Reg_Data,
    output logic                      o_Busy,
    output logic [15:0]               o_Conflict_Cnt,
    output logic [15:0]               o_Zero_Drop_Cnt
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;

    logic               win_valid;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   search_idx;
    logic [PTR_W-1:0]   acc_idx;
    logic               accept;
    logic               acc_lock;
    logic [ADDR_W-1:0]  acc_addr;
    logic [DATA_W-1:0]  acc_data;
    logic               lock_release;

    // Modulo-NUM_REQ increment of a requester index
    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] k);
        if (int'(k) == NUM_REQ - 1) begin
            return '0;
        end
        return k + 1'b1;
    endfunction

    // Rotating priority search starting at ptr
    always_comb begin
        win_valid  = 1'b0;
        win_idx    = ptr;
        search_idx = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!win_valid && i_Req[search_idx]) begin
                win_valid = 1'b1;
                win_idx   = search_idx;
            end
            search_idx = next_idx(search_idx);
        end
    end

    // Grant generation and selection of the accepted requester's payload
    always_comb begin
        o_Grant = '0;
        if (!i_RST && !i_Stall) begin
            if (state == ST_LOCKED) begin
                o_Grant[owner] = i_Req[owner];
            end else if (win_valid) begin
                o_Grant[win_idx] = 1'b1;
            end
        end
        accept   = |o_Grant;
        acc_idx  = (state == ST_LOCKED) ? owner : win_idx;
        acc_lock = 1'b0;
        acc_addr = '0;
        acc_data = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (int'(acc_idx) == k) begin
                acc_lock = i_Lock[k];
                acc_addr = i_Addr[k*ADDR_W +: ADDR_W];
                acc_data = i_Data[k*DATA_W +: DATA_W];
            end
        end
        // Owner stopped requesting in a live cycle: burst ends without a write
        lock_release = (state == ST_LOCKED) && !i_Stall && !i_Req[owner];
    end

    // Arbitration FSM with registered write-port outputs
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            owner            <= '0;
            o_RegWrite       <= 1'b0;
            o_Write_Reg_Addr <= '0;
            o_Write_Reg_Data <= '0;
            o_Busy           <= 1'b0;
        end else begin
            // Register 0 is hardwired, so its writes are accepted but never issued
            o_RegWrite <= accept && (acc_addr != '0);
            if (accept) begin
                o_Write_Reg_Addr <= acc_addr;
                o_Write_Reg_Data <= acc_data;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (acc_lock) begin
                            state  <= ST_LOCKED;
                            owner  <= win_idx;
                            o_Busy <= 1'b1;
                        end else begin
                            ptr <= next_idx(win_idx);
                        end
                    end
                end
                ST_LOCKED: begin
                    if ((accept && !acc_lock) || lock_release) begin
                        state  <= ST_IDLE;
                        o_Busy <= 1'b0;
                        ptr    <= next_idx(owner);
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef REGARB_STATS_EN
    logic [3:0]         req_cnt;
    logic [NUM_REQ-1:0] owner_mask;
    logic               conflict;
    logic [15:0]        conflict_cnt;
    logic [15:0]        zero_cnt;

    // Contention detection: several requesters in IDLE, or an intruder during a burst
    always_comb begin
        req_cnt    = '0;
        owner_mask = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_cnt = req_cnt + {3'b000, i_Req[k]};
        end
        owner_mask[owner] = 1'b1;
        if (state == ST_LOCKED) begin
            conflict = !i_Stall && |(i_Req & ~owner_mask);
        end else begin
            conflict = !i_Stall && (req_cnt >= 4'd2);
        end
    end

    // Saturating statistics counters
    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            conflict_cnt <= '0;
            zero_cnt     <= '0;
        end else begin
            if (conflict && conflict_cnt != 16'hFFFF) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
            if (accept && acc_addr == '0 && zero_cnt != 16'hFFFF) begin
                zero_cnt <= zero_cnt + 16'd1;
            end
        end
    end

    assign o_Conflict_Cnt  = conflict_cnt;
    assign o_Zero_Drop_Cnt = zero_cnt;
`else
    assign o_Conflict_Cnt  = '0;
    assign o_Zero_Drop_Cnt = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic            stall;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] data;
    logic [N-1:0]    grant;
    logic            regwrite;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            busy;
    logic [15:0]     conflict_cnt;
    logic [15:0]     zero_cnt;

    regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .i_CLK            (clk),
        .i_RST            (rst),
        .i_Stall          (stall),
        .i_Req            (req),
        .i_Lock           (lock),
        .i_Addr           (addr),
        .i_Data           (data),
        .o_Grant          (grant),
        .o_RegWrite       (regwrite),
        .o_Write_Reg_Addr (wr_addr),
        .o_Write_Reg_Data (wr_data),
        .o_Busy           (busy),
        .o_Conflict_Cnt   (conflict_cnt),
        .o_Zero_Drop_Cnt  (zero_cnt)
    );

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // pending requester intents
    bit            p_req [N];
    bit            p_lock[N];
    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_data[N];

    // reference model state
    int m_ptr    = 0;
    int m_owner  = 0;
    bit m_locked = 1'b0;
    int m_conf   = 0;
    int m_zero   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sat_inc(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    // Drive one cycle from the pending tables, check the grant, and advance the model
    task automatic drive_cycle(input bit s, input bit r, output logic [N-1:0] act_grant);
        int eg;
        int nreq;
        bit intruder;
        @(negedge clk);
        rst   = r;
        stall = s;
        for (int k = 0; k < N; k++) begin
            req[k]             = p_req[k];
            lock[k]            = p_lock[k];
            addr[k*AW +: AW]   = p_addr[k];
            data[k*DW +: DW]   = p_data[k];
        end
        #1;
        eg = -1;
        if (!r && !s) begin
            if (m_locked) begin
                if (p_req[m_owner]) eg = m_owner;
            end else begin
                for (int i = 0; i < N; i++) begin
                    if (eg < 0 && p_req[(m_ptr + i) % N]) eg = (m_ptr + i) % N;
                end
            end
        end
        act_grant = grant;
        chk("grant", grant, (eg < 0) ? 0 : (1 << eg));
        if (r) begin
            m_ptr = 0; m_owner = 0; m_locked = 1'b0; m_conf = 0; m_zero = 0;
        end else begin
            if (!s) begin
                nreq = 0;
                intruder = 1'b0;
                for (int k = 0; k < N; k++) begin
                    if (p_req[k]) nreq++;
                    if (p_req[k] && k != m_owner) intruder = 1'b1;
                end
                if (m_locked ? intruder : (nreq >= 2)) m_conf = sat_inc(m_conf);
            end
            if (eg >= 0) begin
                exp_t e;
                if (p_addr[eg] != 0) begin
                    e.a = p_addr[eg]; e.d = p_data[eg]; e.cyc = cyc + 1;
                    sb.push_back(e);
                end else begin
                    m_zero = sat_inc(m_zero);
                end
                if (p_lock[eg]) begin
                    m_locked = 1'b1;
                    m_owner  = eg;
                end else begin
                    m_locked = 1'b0;
                    m_ptr    = (eg + 1) % N;
                end
                p_req[eg]  = 1'b0;
                p_lock[eg] = 1'b0;
            end else if (m_locked && !s && !p_req[m_owner]) begin
                m_locked = 1'b0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    endtask

    // Monitor: pops the scoreboard whenever a write appears, checks status outputs
    always begin
        @(posedge clk);
        #2;
        if (mon_en) begin
            if (regwrite) begin
                if (sb.size() == 0) begin
                    chk("unexpected_write", {1'b1, wr_addr}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wr_addr", wr_addr, e.a);
                    chk("wr_data", wr_data, e.d);
                    chk("wr_cycle", cyc, e.cyc);
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                chk("missing_write", 0, {1'b1, e.a});
            end
            chk("busy", busy, m_locked);
            chk("conflict_cnt", conflict_cnt, STATS ? m_conf : 0);
            chk("zero_cnt", zero_cnt, STATS ? m_zero : 0);
        end
    end

    task automatic clear_pending();
        for (int k = 0; k < N; k++) begin
            p_req[k] = 1'b0; p_lock[k] = 1'b0; p_addr[k] = '0; p_data[k] = '0;
        end
    endtask

    initial begin
        logic [N-1:0] g;
        rst = 1'b1; stall = 1'b0; req = '0; lock = '0; addr = '0; data = '0;
        clear_pending();

        drive_cycle(1'b0, 1'b1, g);
        drive_cycle(1'b0, 1'b1, g);
        @(posedge clk);
        #3;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_addr", wr_addr, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        mon_en = 1'b1;

        // round robin across all three requesters
        for (int k = 0; k < N; k++) begin
            p_req[k] = 1'b1; p_addr[k] = AW'(k + 1); p_data[k] = DW'(k + 10);
        end
        drive_cycle(1'b0, 1'b0, g); chk("t1_g0", g, 3'b001);
        drive_cycle(1'b0, 1'b0, g); chk("t1_g1", g, 3'b010);
        drive_cycle(1'b0, 1'b0, g); chk("t1_g2", g, 3'b100);

        // locked burst by requester 1 with requester 0 waiting
        p_req[1] = 1'b1; p_lock[1] = 1'b1; p_addr[1] = 5'd5; p_data[1] = 32'h55;
        drive_cycle(1'b0, 1'b0, g); chk("t2_g0", g, 3'b010);
        p_req[0] = 1'b1; p_addr[0] = 5'd9; p_data[0] = 32'h99;
        p_req[1] = 1'b1; p_lock[1] = 1'b1; p_addr[1] = 5'd6; p_data[1] = 32'h66;
        drive_cycle(1'b0, 1'b0, g); chk("t2_g1", g, 3'b010);
        p_req[1] = 1'b1; p_lock[1] = 1'b0; p_addr[1] = 5'd7; p_data[1] = 32'h77;
        drive_cycle(1'b0, 1'b0, g); chk("t2_g2", g, 3'b010);
        drive_cycle(1'b0, 1'b0, g); chk("t2_g3", g, 3'b001);

        // write to register 0 is granted but dropped
        p_req[2] = 1'b1; p_addr[2] = 5'd0; p_data[2] = 32'hDEADBEEF;
        drive_cycle(1'b0, 1'b0, g); chk("t3_grant", g, 3'b100);
        @(posedge clk);
        #3;
        chk("t3_regwrite", regwrite, 0);
        chk("t3_zero_cnt", zero_cnt, STATS ? 1 : 0);

        // stall holds everything
        p_req[0] = 1'b1; p_addr[0] = 5'd12; p_data[0] = 32'hC0;
        p_req[1] = 1'b1; p_addr[1] = 5'd13; p_data[1] = 32'hC1;
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 1'b0, g); chk("t4_stall_grant", g, 3'b000);
        end
        drive_cycle(1'b0, 1'b0, g); chk("t4_after0", g, 3'b001);
        drive_cycle(1'b0, 1'b0, g); chk("t4_after1", g, 3'b010);

        // reset in the middle of a burst
        p_req[0] = 1'b1; p_lock[0] = 1'b1; p_addr[0] = 5'd3; p_data[0] = 32'h33;
        drive_cycle(1'b0, 1'b0, g); chk("t5_lock", g, 3'b001);
        p_req[0] = 1'b1; p_lock[0] = 1'b1; p_addr[0] = 5'd4; p_data[0] = 32'h44;
        drive_cycle(1'b0, 1'b1, g);
        p_lock[0] = 1'b0;
        p_req[2] = 1'b1; p_addr[2] = 5'd20; p_data[2] = 32'h2020;
        drive_cycle(1'b0, 1'b0, g); chk("t5_after0", g, 3'b001);
        drive_cycle(1'b0, 1'b0, g); chk("t5_after1", g, 3'b100);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            bit s;
            bit r;
            for (int k = 0; k < N; k++) begin
                if (!p_req[k] && $urandom_range(0, 2) == 0) begin
                    p_req[k]  = 1'b1;
                    p_lock[k] = ($urandom_range(0, 3) == 0);
                    p_addr[k] = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, 31));
                    p_data[k] = $urandom;
                end
            end
            s = ($urandom_range(0, 7) == 0);
            r = ($urandom_range(0, 99) == 0);
            drive_cycle(s, r, g);
        end

        clear_pending();
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, g);
        @(posedge clk);
        #3;
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
